// File: rtl/postmortem_capture.sv
// Postmortem capture buffer: records NUM_CH channel samples into a circular RAM,
// freezes POST_TRIG samples after a fault trigger, and exposes a read port for paging.
module postmortem_capture #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 10,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int POST_TRIG  = 256
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_sample_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_data,
   input  logic                         i_trigger,
   input  logic                         i_arm,
   input  logic [31:0]                  i_r_ram_addr,
   output logic [NUM_CH*DATA_WIDTH-1:0] o_r_ram_data,
   output logic [31:0]                  o_w_ram_addr,
   output logic [31:0]                  o_trig_addr,
   output logic [1:0]                   o_state,
   output logic                         o_wrapped
);

   localparam int RamWidth = NUM_CH * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      POST   = 2'd2,
      FROZEN = 2'd3
   } CaptureState;

   CaptureState           r_state, w_stateNext;
   logic [ADDR_WIDTH-1:0] r_wptr, w_wptrNext;
   logic [ADDR_WIDTH-1:0] r_trigAddr, w_trigAddrNext;
   logic [ADDR_WIDTH-1:0] r_postCnt, w_postCntNext;
   logic                  r_wrapped, w_wrappedNext;
   logic                  r_trigPending, w_trigPendingNext;
   logic                  w_wrEn;
   logic [ADDR_WIDTH-1:0] w_rdAddr;
   logic [31-ADDR_WIDTH:0] w_unusedAddrBits;
   logic [RamWidth-1:0]   r_mem [DEPTH];
   logic [RamWidth-1:0]   r_rdData;

   assign w_rdAddr         = i_r_ram_addr[ADDR_WIDTH-1:0];
   assign w_unusedAddrBits = i_r_ram_addr[31:ADDR_WIDTH];
   assign w_wrEn           = ((r_state == ARMED) || (r_state == POST)) && i_sample_valid;

   // Memory arrays carry no reset so they map onto block RAM; read-first ordering
   // falls out of the non-blocking write/read pair.
   always_ff @(posedge i_clk) begin
      if (w_wrEn)
         r_mem[r_wptr] <= i_ch_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_rdData <= '0;
      else
         r_rdData <= r_mem[w_rdAddr];
   end

   // A trigger seen without a sample is held so the trigger sample is always the
   // first sample at or after trigger assertion.
   always_comb begin
      w_stateNext       = r_state;
      w_wptrNext        = r_wptr;
      w_trigAddrNext    = r_trigAddr;
      w_postCntNext     = r_postCnt;
      w_wrappedNext     = r_wrapped;
      w_trigPendingNext = r_trigPending;

      if (w_wrEn) begin
         w_wptrNext = r_wptr + 1'b1;
         if (r_wptr == ADDR_WIDTH'(DEPTH - 1))
            w_wrappedNext = 1'b1;
      end

      case (r_state)
         IDLE, FROZEN: begin
            if (i_arm) begin
               w_stateNext       = ARMED;
               w_wptrNext        = '0;
               w_wrappedNext     = 1'b0;
               w_trigPendingNext = 1'b0;
            end
         end
         ARMED: begin
            if (i_sample_valid && (i_trigger || r_trigPending)) begin
               w_stateNext       = POST;
               w_trigAddrNext    = r_wptr;
               w_postCntNext     = ADDR_WIDTH'(POST_TRIG);
               w_trigPendingNext = 1'b0;
            end else if (i_trigger) begin
               w_trigPendingNext = 1'b1;
            end
         end
         POST: begin
            if (i_sample_valid) begin
               w_postCntNext = r_postCnt - 1'b1;
               if (r_postCnt == ADDR_WIDTH'(1))
                  w_stateNext = FROZEN;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_wptr        <= '0;
         r_trigAddr    <= '0;
         r_postCnt     <= '0;
         r_wrapped     <= 1'b0;
         r_trigPending <= 1'b0;
      end else begin
         r_state       <= w_stateNext;
         r_wptr        <= w_wptrNext;
         r_trigAddr    <= w_trigAddrNext;
         r_postCnt     <= w_postCntNext;
         r_wrapped     <= w_wrappedNext;
         r_trigPending <= w_trigPendingNext;
      end
   end

   assign o_r_ram_data = r_rdData;
   assign o_w_ram_addr = 32'(r_wptr);
   assign o_trig_addr  = 32'(r_trigAddr);
   assign o_state      = r_state;
   assign o_wrapped    = r_wrapped;

endmodule
